// File: rtl/fifo_pkt_tx.sv
// fifo_pkt_tx: read side of the packet FIFO, frames committed packets onto a valid/ready link with inter-frame gap; FIFO_PKT_TX_CNT_EN adds the pkt_cnt port
module fifo_pkt_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 6,
  parameter int IFG_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_empty,
  output logic                  fifo_pop,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  tx_sop,
  output logic                  tx_eop,
  output logic                  busy,
`ifdef FIFO_PKT_TX_CNT_EN
  output logic [15:0]           pkt_cnt,
`endif
  output logic                  underrun
);
  localparam int GW = IFG_CYCLES > 1 ? $clog2(IFG_CYCLES + 1) : 1;
  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_CRC, S_GAP} state_t;
  state_t               state, state_nx;
  logic [LEN_WIDTH-1:0] rem;
  logic [GW-1:0]        gap;
  logic                 free, load;
  assign free = !tx_valid || tx_ready;
  assign load = !fifo_empty && free && state != S_GAP;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_nx;
  // next-state: state names the class of the next byte to load; the gap counts output-free cycles after eop
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (load) state_nx = fifo_data[LEN_WIDTH-1:0] == '0 ? S_CRC : S_PAYLOAD;
      S_PAYLOAD: if (load && rem == LEN_WIDTH'(1)) state_nx = S_CRC;
      S_CRC:     if (load) state_nx = IFG_CYCLES == 0 ? S_IDLE : S_GAP;
      default:   if (free && gap == GW'(1)) state_nx = S_IDLE;
    endcase
  end
  // combinational outputs
  always_comb begin
    fifo_pop = load;
    busy     = state != S_IDLE || tx_valid;
  end
  // output byte register with framing; holds everything while the sink stalls
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tx_data  <= '0;
      tx_valid <= 1'b0;
      tx_sop   <= 1'b0;
      tx_eop   <= 1'b0;
    end else if (load) begin
      tx_data  <= fifo_data;
      tx_valid <= 1'b1;
      tx_sop   <= state == S_IDLE;
      tx_eop   <= state == S_CRC;
    end else if (tx_ready) begin
      tx_valid <= 1'b0;
      tx_sop   <= 1'b0;
      tx_eop   <= 1'b0;
    end
  // payload remaining, gap countdown and sticky underrun
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rem      <= '0;
      gap      <= '0;
      underrun <= 1'b0;
    end else begin
      if (load && state == S_IDLE) rem <= fifo_data[LEN_WIDTH-1:0];
      else if (load && state == S_PAYLOAD && rem != '0) rem <= rem - LEN_WIDTH'(1);
      if (load && state == S_CRC) gap <= GW'(IFG_CYCLES);
      else if (state == S_GAP && free && gap != '0) gap <= gap - GW'(1);
      if (fifo_empty && (state == S_PAYLOAD || state == S_CRC)) underrun <= 1'b1;
    end
`ifdef FIFO_PKT_TX_CNT_EN
  // saturating count of accepted eop bytes
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pkt_cnt <= '0;
    else if (tx_valid && tx_ready && tx_eop && pkt_cnt != 16'hFFFF) pkt_cnt <= pkt_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_fifo_pkt_tx.sv
// tb_fifo_pkt_tx: table-driven bench for fifo_pkt_tx with a small FIFO model per instance
module tb_fifo_pkt_tx;
  logic clk = 1'b0;
  logic rst_n, tx_ready, hole;
  logic [7:0] fifo_data, tx_data, fifo_data0, tx_data0;
  logic fifo_empty, fifo_pop, tx_valid, tx_sop, tx_eop, busy, underrun;
  logic fifo_empty0, fifo_pop0, tx_valid0, tx_sop0, tx_eop0, busy0, underrun0;
`ifdef FIFO_PKT_TX_CNT_EN
  logic [15:0] pkt_cnt, pkt_cnt0;
`endif
  logic [7:0] mem [0:255];
  logic [7:0] mem0 [0:255];
  int wr = 0, rd = 0, wr0 = 0, rd0 = 0;
  int total = 0, passed = 0;
  always #5 clk = ~clk;
  assign fifo_empty  = (rd == wr) || hole;
  assign fifo_data   = mem[rd[7:0]];
  assign fifo_empty0 = rd0 == wr0;
  assign fifo_data0  = mem0[rd0[7:0]];
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd  <= wr;
      rd0 <= wr0;
    end else begin
      if (fifo_pop) rd <= rd + 1;
      if (fifo_pop0) rd0 <= rd0 + 1;
    end
  fifo_pkt_tx #(.IFG_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
    .fifo_pop(fifo_pop), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_sop(tx_sop), .tx_eop(tx_eop), .busy(busy),
`ifdef FIFO_PKT_TX_CNT_EN
    .pkt_cnt(pkt_cnt),
`endif
    .underrun(underrun));
  fifo_pkt_tx #(.IFG_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .fifo_data(fifo_data0), .fifo_empty(fifo_empty0),
    .fifo_pop(fifo_pop0), .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(1'b1),
    .tx_sop(tx_sop0), .tx_eop(tx_eop0), .busy(busy0),
`ifdef FIFO_PKT_TX_CNT_EN
    .pkt_cnt(pkt_cnt0),
`endif
    .underrun(underrun0));
  typedef struct {
    bit rdy, hole, v;
    logic [7:0] d;
    bit sop, eop, pop, busy, ur;
  } vec_t;
  vec_t tv[$];
  task automatic add(input bit rdy, input bit h, input bit v, input logic [7:0] d,
                     input bit sop, input bit eop, input bit pop, input bit b, input bit ur);
    vec_t r;
    r.rdy = rdy; r.hole = h; r.v = v; r.d = d; r.sop = sop; r.eop = eop;
    r.pop = pop; r.busy = b; r.ur = ur;
    tv.push_back(r);
  endtask
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask
  task automatic push(input int n, input logic [39:0] bytes);
    @(posedge clk);
    #1;
    for (int i = 0; i < n; i++) begin
      mem[wr[7:0]] = bytes[8*(n-1-i) +: 8];
      wr++;
    end
  endtask
  task automatic run(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      tx_ready = tv[i].rdy;
      hole = tv[i].hole;
      #1;
      check($sformatf("row%0d valid", i), {31'b0, tx_valid}, {31'b0, tv[i].v});
      if (tv[i].v) check($sformatf("row%0d data", i), {24'b0, tx_data}, {24'b0, tv[i].d});
      check($sformatf("row%0d sop", i), {31'b0, tx_sop}, {31'b0, tv[i].sop});
      check($sformatf("row%0d eop", i), {31'b0, tx_eop}, {31'b0, tv[i].eop});
      check($sformatf("row%0d pop", i), {31'b0, fifo_pop}, {31'b0, tv[i].pop});
      check($sformatf("row%0d busy", i), {31'b0, busy}, {31'b0, tv[i].busy});
      check($sformatf("row%0d underrun", i), {31'b0, underrun}, {31'b0, tv[i].ur});
    end
  endtask
  task automatic check_zero(input string tag);
    check({tag, " valid"}, {31'b0, tx_valid}, 0);
    check({tag, " data"}, {24'b0, tx_data}, 0);
    check({tag, " sop"}, {31'b0, tx_sop}, 0);
    check({tag, " eop"}, {31'b0, tx_eop}, 0);
    check({tag, " busy"}, {31'b0, busy}, 0);
    check({tag, " underrun"}, {31'b0, underrun}, 0);
    check({tag, " pop"}, {31'b0, fifo_pop}, 0);
`ifdef FIFO_PKT_TX_CNT_EN
    check({tag, " pkt_cnt"}, {16'b0, pkt_cnt}, 0);
`endif
  endtask
  initial begin
    logic [7:0] e0_d [0:6];
    bit e0_v [0:6];
    bit e0_s [0:6];
    bit e0_e [0:6];
    e0_d = '{8'h00, 8'h01, 8'hB1, 8'hC1, 8'h00, 8'hC2, 8'h00};
    e0_v = '{0, 1, 1, 1, 1, 1, 0};
    e0_s = '{0, 1, 0, 0, 1, 0, 0};
    e0_e = '{0, 0, 0, 1, 0, 1, 0};
    // test 1: rows 0-6
    add(1,0,0,8'h00,0,0,1,0,0); add(1,0,1,8'h02,1,0,1,1,0); add(1,0,1,8'hA1,0,0,1,1,0);
    add(1,0,1,8'hA2,0,0,1,1,0); add(1,0,1,8'hC7,0,1,0,1,0); add(1,0,0,8'h00,0,0,0,1,0);
    add(1,0,0,8'h00,0,0,0,0,0);
    // test 2: rows 7-16, sink stalls on A1
    add(1,0,0,8'h00,0,0,1,0,0); add(1,0,1,8'h02,1,0,1,1,0); add(0,0,1,8'hA1,0,0,0,1,0);
    add(0,0,1,8'hA1,0,0,0,1,0); add(0,0,1,8'hA1,0,0,0,1,0); add(1,0,1,8'hA1,0,0,1,1,0);
    add(1,0,1,8'hA2,0,0,1,1,0); add(1,0,1,8'hC7,0,1,0,1,0); add(1,0,0,8'h00,0,0,0,1,0);
    add(1,0,0,8'h00,0,0,0,0,0);
    // test 3: rows 17-21, zero-length payload
    add(1,0,0,8'h00,0,0,1,0,0); add(1,0,1,8'h00,1,0,1,1,0); add(1,0,1,8'h5A,0,1,0,1,0);
    add(1,0,0,8'h00,0,0,0,1,0); add(1,0,0,8'h00,0,0,0,0,0);
    // test 4: rows 22-31, back-to-back packets with a 2-cycle gap
    add(1,0,0,8'h00,0,0,1,0,0); add(1,0,1,8'h01,1,0,1,1,0); add(1,0,1,8'hB1,0,0,1,1,0);
    add(1,0,1,8'hC1,0,1,0,1,0); add(1,0,0,8'h00,0,0,0,1,0); add(1,0,0,8'h00,0,0,1,0,0);
    add(1,0,1,8'h00,1,0,1,1,0); add(1,0,1,8'hC2,0,1,0,1,0); add(1,0,0,8'h00,0,0,0,1,0);
    add(1,0,0,8'h00,0,0,0,0,0);
    // test 5: rows 32-44, FIFO hole of 5 cycles after first payload byte
    add(1,0,0,8'h00,0,0,1,0,0); add(1,0,1,8'h03,1,0,1,1,0); add(1,1,1,8'hD1,0,0,0,1,0);
    add(1,1,0,8'h00,0,0,0,1,1); add(1,1,0,8'h00,0,0,0,1,1); add(1,1,0,8'h00,0,0,0,1,1);
    add(1,1,0,8'h00,0,0,0,1,1); add(1,0,0,8'h00,0,0,1,1,1); add(1,0,1,8'hD2,0,0,1,1,1);
    add(1,0,1,8'hD3,0,0,1,1,1); add(1,0,1,8'hC3,0,1,0,1,1); add(1,0,0,8'h00,0,0,0,1,1);
    add(1,0,0,8'h00,0,0,0,0,1);
    // test 6: rows 45-47 start a packet, rows 48-52 follow the reset
    add(1,0,0,8'h00,0,0,1,0,1); add(1,0,1,8'h03,1,0,1,1,1); add(1,0,1,8'hE1,0,0,1,1,1);
    add(1,0,0,8'h00,0,0,1,0,0); add(1,0,1,8'h00,1,0,1,1,0); add(1,0,1,8'h5A,0,1,0,1,0);
    add(1,0,0,8'h00,0,0,0,1,0); add(1,0,0,8'h00,0,0,0,0,0);
    rst_n = 1'b0; tx_ready = 1'b1; hole = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    push(4, 40'h02A1A2C7); run(0, 6);
    push(4, 40'h02A1A2C7); run(7, 16);
    push(2, 40'h005A);     run(17, 21);
    push(5, 40'h01B1C100C2); run(22, 31);
    push(5, 40'h03D1D2D3C3); run(32, 44);
`ifdef FIFO_PKT_TX_CNT_EN
    check("pkt_cnt before reset", {16'b0, pkt_cnt}, 6);
`endif
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      mem0[wr0[7:0]] = e0_d[i+1];
      wr0++;
    end
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("ifg0 c%0d valid", i), {31'b0, tx_valid0}, {31'b0, e0_v[i]});
      if (e0_v[i]) check($sformatf("ifg0 c%0d data", i), {24'b0, tx_data0}, {24'b0, e0_d[i]});
      check($sformatf("ifg0 c%0d sop", i), {31'b0, tx_sop0}, {31'b0, e0_s[i]});
      check($sformatf("ifg0 c%0d eop", i), {31'b0, tx_eop0}, {31'b0, e0_e[i]});
    end
    push(5, 40'h03E1E2E3CE); run(45, 47);
    #2 rst_n = 1'b0;
    #1 check_zero("async reset");
    @(negedge clk);
    rst_n = 1'b1;
    push(2, 40'h005A); run(48, 52);
`ifdef FIFO_PKT_TX_CNT_EN
    check("pkt_cnt after reset", {16'b0, pkt_cnt}, 1);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
